// File: rtl/reg_write_arb_if.sv
// Handshake and write-port bundle between two register-file writers and the write arbiter.
// The requester side uses master and the arbiter uses slave.
interface reg_write_arb_if;
   logic        REQ_A;
   logic        LOCK_A;
   logic [2:0]  DR_A;
   logic [15:0] DATA_A;
   logic        REQ_B;
   logic        LOCK_B;
   logic [2:0]  DR_B;
   logic [15:0] DATA_B;
   logic        GNT_A;
   logic        GNT_B;
   logic        LD_REG;
   logic [2:0]  DR;
   logic [15:0] DataBus;
   logic [1:0]  OWNER;

   modport master (
      output REQ_A, LOCK_A, DR_A, DATA_A,
      output REQ_B, LOCK_B, DR_B, DATA_B,
      input  GNT_A, GNT_B, LD_REG, DR, DataBus, OWNER
   );

   modport slave (
      input  REQ_A, LOCK_A, DR_A, DATA_A,
      input  REQ_B, LOCK_B, DR_B, DATA_B,
      output GNT_A, GNT_B, LD_REG, DR, DataBus, OWNER
   );
endinterface

// File: rtl/reg_write_arb.sv
// Two-requester register-file write arbiter with round-robin and bounded lock bursts.
// Define REG_WRITE_ARB_FIXED_PRIO_EN to make A always win in IDLE and ignore LOCK_B.
module reg_write_arb #(
   parameter int unsigned BURST_MAX = 4
) (
   input logic           CLK,
   input logic           Reset,
   reg_write_arb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_A = 2'b01,
      OWN_B = 2'b10
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(BURST_MAX);

`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        ptr_b_reg, ptr_b_next;
   logic        ld_en_reg, ld_en_next;
   logic [2:0]  dr_reg, dr_next;
   logic [15:0] data_reg, data_next;

   logic        gnt_a;
   logic        gnt_b;
   logic        lock_b_eff;
   logic [3:0]  cnt_inc;
   logic [3:0]  cnt_try;

`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
   assign lock_b_eff = bus.LOCK_B & 1'b0;
`else
   assign lock_b_eff = bus.LOCK_B;
`endif

   assign cnt_inc = (cnt_reg >= MAX_CNT) ? MAX_CNT : cnt_reg + 4'd1;

   // State register, burst counter, round-robin pointer and the registered write port.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         ptr_b_reg <= 1'b0;
         ld_en_reg <= 1'b0;
         dr_reg    <= 3'b000;
         data_reg  <= 16'h0000;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ptr_b_reg <= ptr_b_next;
         ld_en_reg <= ld_en_next;
         dr_reg    <= dr_next;
         data_reg  <= data_next;
      end
   end

   // Next state: every grant chooses the following owner from its own LOCK bit.
   always_comb begin
      state_next = IDLE;
      cnt_next   = 4'd0;
      ptr_b_next = ptr_b_reg;
      ld_en_next = 1'b0;
      dr_next    = dr_reg;
      data_next  = data_reg;
      cnt_try    = 4'd1;
      if (gnt_a) begin
         ld_en_next = 1'b1;
         dr_next    = bus.DR_A;
         data_next  = bus.DATA_A;
         ptr_b_next = 1'b1;
         if (bus.LOCK_A) begin
            cnt_try = (state_reg == OWN_A) ? cnt_inc : 4'd1;
            if (!(cnt_try == MAX_CNT && bus.REQ_B)) begin
               state_next = OWN_A;
               cnt_next   = cnt_try;
            end
         end
      end else if (gnt_b) begin
         ld_en_next = 1'b1;
         dr_next    = bus.DR_B;
         data_next  = bus.DATA_B;
         ptr_b_next = 1'b0;
         if (lock_b_eff) begin
            cnt_try = (state_reg == OWN_B) ? cnt_inc : 4'd1;
            if (!(cnt_try == MAX_CNT && bus.REQ_A)) begin
               state_next = OWN_B;
               cnt_next   = cnt_try;
            end
         end
      end
   end

   // Grants: the owner wins while requesting, otherwise the other side may use the slot.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!Reset) begin
         unique case (state_reg)
            OWN_A: begin
               if (bus.REQ_A) gnt_a = 1'b1;
               else           gnt_b = bus.REQ_B;
            end
            OWN_B: begin
               if (bus.REQ_B) gnt_b = 1'b1;
               else           gnt_a = bus.REQ_A;
            end
            default: begin
               if (bus.REQ_A && bus.REQ_B) begin
                  if (FIXED_PRIO || !ptr_b_reg) gnt_a = 1'b1;
                  else                          gnt_b = 1'b1;
               end else begin
                  gnt_a = bus.REQ_A;
                  gnt_b = bus.REQ_B;
               end
            end
         endcase
      end
   end

   assign bus.GNT_A   = gnt_a;
   assign bus.GNT_B   = gnt_b;
   // Outputs are forced to reset values while Reset is high, killing a write pending from the last grant.
   assign bus.LD_REG  = ld_en_reg & ~Reset;
   assign bus.DR      = Reset ? 3'b000 : dr_reg;
   assign bus.DataBus = Reset ? 16'h0000 : data_reg;
   assign bus.OWNER   = Reset ? 2'b00 : state_reg;

endmodule

// File: tb/tb_reg_write_arb.sv
// Self-checking bench for reg_write_arb: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_reg_write_arb;
   localparam int BMAX = 4;
`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic CLK = 1'b0;
   logic Reset = 1'b1;
   always #5 CLK = ~CLK;

   reg_write_arb_if bus ();

   reg_write_arb #(.BURST_MAX(BMAX)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: who owns the slot (0 none, 1 A, 2 B), burst length, who is favoured, visible write port.
   int          m_owner = 0;
   int          m_cnt   = 0;
   bit          m_fav_b = 1'b0;
   bit          m_ld    = 1'b0;
   logic [2:0]  m_dr    = 3'd0;
   logic [15:0] m_data  = 16'h0;
   bit          e_ga, e_gb;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic take(input int who, input bit lock, input bit other_req);
      int n;
      if (!lock) begin
         m_owner = 0;
         m_cnt   = 0;
      end else begin
         n = (m_owner == who) ? ((m_cnt + 1 > BMAX) ? BMAX : m_cnt + 1) : 1;
         if (n == BMAX && other_req) begin
            m_owner = 0;
            m_cnt   = 0;
         end else begin
            m_owner = who;
            m_cnt   = n;
         end
      end
   endtask

   task automatic cycle(input bit rst,
                        input bit ra, input bit la, input logic [2:0] da, input logic [15:0] xa,
                        input bit rb, input bit lb, input logic [2:0] db, input logic [15:0] xb);
      @(negedge CLK);
      cyc++;
      Reset = rst;
      bus.REQ_A = ra; bus.LOCK_A = la; bus.DR_A = da; bus.DATA_A = xa;
      bus.REQ_B = rb; bus.LOCK_B = lb; bus.DR_B = db; bus.DATA_B = xb;
      #1;
      e_ga = 1'b0;
      e_gb = 1'b0;
      if (!rst) begin
         if (m_owner == 1) begin
            if (ra) e_ga = 1'b1; else e_gb = rb;
         end else if (m_owner == 2) begin
            if (rb) e_gb = 1'b1; else e_ga = ra;
         end else if (ra && rb) begin
            if (FIXED || !m_fav_b) e_ga = 1'b1; else e_gb = 1'b1;
         end else begin
            e_ga = ra;
            e_gb = rb;
         end
      end
      chk("GNT_A",   16'(bus.GNT_A),   16'(e_ga));
      chk("GNT_B",   16'(bus.GNT_B),   16'(e_gb));
      chk("LD_REG",  16'(bus.LD_REG),  rst ? 16'h0 : 16'(m_ld));
      chk("DR",      16'(bus.DR),      rst ? 16'h0 : 16'(m_dr));
      chk("DataBus", bus.DataBus,      rst ? 16'h0 : m_data);
      chk("OWNER",   16'(bus.OWNER),   rst ? 16'h0 : 16'(m_owner));
      if (e_ga) $display("cyc %0d xfer A dr=%0d data=%h lock=%0d", cyc, da, xa, la);
      if (e_gb) $display("cyc %0d xfer B dr=%0d data=%h lock=%0d", cyc, db, xb, lb);
      if (rst) begin
         m_owner = 0; m_cnt = 0; m_fav_b = 1'b0;
         m_ld = 1'b0; m_dr = 3'd0; m_data = 16'h0;
      end else begin
         m_ld = e_ga | e_gb;
         if (e_ga) begin
            m_dr = da; m_data = xa; m_fav_b = 1'b1;
            take(1, la, rb);
         end else if (e_gb) begin
            m_dr = db; m_data = xb; m_fav_b = 1'b0;
            take(2, lb && !FIXED, ra);
         end else begin
            m_owner = 0;
            m_cnt   = 0;
         end
      end
   endtask

   task automatic idle_cycle();
      cycle(0, 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
   endtask

   task automatic reset_cycle();
      cycle(1, 0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 16'h0);
   endtask

   bit          ra, la, rb, lb, rst, hold_a, hold_b;
   logic [2:0]  da, db;
   logic [15:0] xa, xb;

   initial begin
      bus.REQ_A = 0; bus.LOCK_A = 0; bus.DR_A = 0; bus.DATA_A = 0;
      bus.REQ_B = 0; bus.LOCK_B = 0; bus.DR_B = 0; bus.DATA_B = 0;

      // Reset state
      reset_cycle();
      reset_cycle();

      // Single write from A lands one cycle after the grant, then LD_REG drops
      cycle(0, 1, 0, 3'd3, 16'h1234, 0, 0, 3'd0, 16'h0);
      chk("single_gnt_a", 16'(bus.GNT_A), 16'h1);
      idle_cycle();
      chk("single_ld", 16'(bus.LD_REG), 16'h1);
      chk("single_dr", 16'(bus.DR), 16'h3);
      chk("single_data", bus.DataBus, 16'h1234);
      idle_cycle();
      chk("single_ld_off", 16'(bus.LD_REG), 16'h0);
      chk("single_dr_hold", 16'(bus.DR), 16'h3);

      // Round robin, no lock: A,B,A,B
      reset_cycle();
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 0, 3'd1, 16'(16'hA000 + i), 1, 0, 3'd2, 16'(16'hB000 + i));
         if (!FIXED) chk("rr_gnt_a", 16'(bus.GNT_A), 16'((i % 2) == 0));
      end
      idle_cycle();
      chk("rr_last_ld", 16'(bus.LD_REG), 16'h1);

      // Locked A burst of BURST_MAX, then B
      reset_cycle();
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1, 3'(i), 16'(16'hC000 + i), 1, 0, 3'd7, 16'hD00D);
         chk("burst_gnt_a", 16'(bus.GNT_A), 16'(i < 4));
         chk("burst_owner", 16'(bus.OWNER), (i == 0 || i == 4) ? 16'h0 : 16'h1);
      end

      // Locked B drops its request for a cycle; A gets that slot and ownership ends
      reset_cycle();
      cycle(0, 0, 0, 3'd0, 16'h0, 1, 1, 3'd4, 16'h4444);
      cycle(0, 0, 0, 3'd0, 16'h0, 1, 1, 3'd4, 16'h4445);
      cycle(0, 1, 0, 3'd5, 16'h5555, 0, 1, 3'd4, 16'h0);
      chk("drop_gnt_a", 16'(bus.GNT_A), 16'h1);
      idle_cycle();
      chk("drop_owner", 16'(bus.OWNER), 16'h0);

      // Same destination from both: both writes happen, the later one wins
      reset_cycle();
      cycle(0, 1, 0, 3'd2, 16'h1111, 1, 0, 3'd2, 16'h2222);
      cycle(0, 0, 0, 3'd0, 16'h0, 1, 0, 3'd2, 16'h2222);
      idle_cycle();
      chk("samedr_data", bus.DataBus, 16'h2222);

      // Reset the cycle after a grant suppresses that write
      reset_cycle();
      cycle(0, 1, 0, 3'd5, 16'hBEEF, 0, 0, 3'd0, 16'h0);
      cycle(1, 1, 1, 3'd6, 16'hCAFE, 1, 1, 3'd6, 16'hCAFE);
      chk("rst_ld", 16'(bus.LD_REG), 16'h0);
      chk("rst_dr", 16'(bus.DR), 16'h0);
      chk("rst_data", bus.DataBus, 16'h0);
      idle_cycle();
      chk("rst_ld_after", 16'(bus.LD_REG), 16'h0);

`ifdef REG_WRITE_ARB_FIXED_PRIO_EN
      reset_cycle();
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 0, 3'd1, 16'h0A0A, 1, 1, 3'd2, 16'h0B0B);
         chk("fixed_gnt_a", 16'(bus.GNT_A), 16'h1);
         chk("fixed_owner_b", 16'(bus.OWNER == 2'b10), 16'h0);
      end
`endif

      // Random traffic; a refused request is held with stable DR/DATA
      hold_a = 0; hold_b = 0;
      da = 0; db = 0; xa = 0; xb = 0;
      reset_cycle();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!hold_a) begin
            ra = ($urandom_range(0, 2) != 0);
            da = 3'($urandom);
            xa = 16'($urandom);
         end
         if (!hold_b) begin
            rb = ($urandom_range(0, 2) != 0);
            db = 3'($urandom);
            xb = 16'($urandom);
         end
         la = ($urandom_range(0, 3) != 0);
         lb = ($urandom_range(0, 3) != 0);
         cycle(rst, ra, la, da, xa, rb, lb, db, xb);
         hold_a = ra && !e_ga && !rst;
         hold_b = rb && !e_gb && !rst;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
